// File: rtl/tilelink_ul_master_adapter.sv
// tilelink_ul_master_adapter
// Single-outstanding TileLink-UL master. Converts a host request/response
// handshake into A-channel Get/PutFullData/PutPartialData and collects the
// matching D-channel AccessAck/AccessAckData. Each transaction carries a
// rolling source ID; D beats with a foreign source are dropped as stale.
// Optional D-wait timeout is enabled by defining TL_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps

module tilelink_ul_master_adapter #(
  parameter int TL_ADDR_WIDTH   = 64,
  parameter int TL_DATA_WIDTH   = 64,
  parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
  parameter int TL_SOURCE_WIDTH = 3,
  parameter int TL_SINK_WIDTH   = 3,
  parameter int TL_OPCODE_WIDTH = 3,
  parameter int TL_PARAM_WIDTH  = 3,
  parameter int TL_SIZE_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  // host request
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [TL_ADDR_WIDTH-1:0]   req_addr,
  input  logic [TL_DATA_WIDTH-1:0]   req_wdata,
  input  logic [TL_STRB_WIDTH-1:0]   req_wmask,
  // host response
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [TL_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                       rsp_error,
  output logic                       rsp_timeout,
  // A channel
  output logic                       a_valid,
  output logic [TL_OPCODE_WIDTH-1:0] a_opcode,
  output logic [TL_PARAM_WIDTH-1:0]  a_param,
  output logic [TL_ADDR_WIDTH-1:0]   a_address,
  output logic [TL_SIZE_WIDTH-1:0]   a_size,
  output logic [TL_STRB_WIDTH-1:0]   a_mask,
  output logic [TL_DATA_WIDTH-1:0]   a_data,
  output logic [TL_SOURCE_WIDTH-1:0] a_source,
  input  logic                       a_ready,
  // D channel
  input  logic                       d_valid,
  input  logic [TL_OPCODE_WIDTH-1:0] d_opcode,
  input  logic [TL_PARAM_WIDTH-1:0]  d_param,
  input  logic [TL_SIZE_WIDTH-1:0]   d_size,
  input  logic [TL_SINK_WIDTH-1:0]   d_sink,
  input  logic [TL_SOURCE_WIDTH-1:0] d_source,
  input  logic [TL_DATA_WIDTH-1:0]   d_data,
  input  logic                       d_error,
  output logic                       d_ready,
  output logic                       stale_drop
);

  localparam int OFF = (TL_STRB_WIDTH > 1) ? $clog2(TL_STRB_WIDTH) : 0;
  localparam logic [TL_ADDR_WIDTH-1:0] ADDR_LOW = TL_ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

  localparam logic [TL_OPCODE_WIDTH-1:0] OP_PUT_FULL    = TL_OPCODE_WIDTH'(0);
  localparam logic [TL_OPCODE_WIDTH-1:0] OP_PUT_PARTIAL = TL_OPCODE_WIDTH'(1);
  localparam logic [TL_OPCODE_WIDTH-1:0] OP_GET         = TL_OPCODE_WIDTH'(4);
  localparam logic [TL_OPCODE_WIDTH-1:0] OP_ACK         = TL_OPCODE_WIDTH'(0);
  localparam logic [TL_OPCODE_WIDTH-1:0] OP_ACK_DATA    = TL_OPCODE_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    A_SEND = 2'd1,
    D_WAIT = 2'd2,
    RSP    = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [TL_SOURCE_WIDTH-1:0] src_ctr_q;
  logic                       is_get_q;

  logic req_fire;
  logic d_beat;
  logic d_match;
  logic d_stale;
  logic to_hit;

  // Handshakes are qualified by the registered ready/valid outputs so the
  // host never sees a request accepted while req_ready is still low.
  assign req_fire = req_ready && req_valid;
  assign d_beat   = d_ready && d_valid;
  assign d_match  = d_beat && (d_source == a_source);
  assign d_stale  = d_beat && (d_source != a_source);

  // d_param, d_size and d_sink carry nothing this master needs.
  logic unused_inputs;
  assign unused_inputs = (^{d_param, d_size, d_sink}) ^ (TIMEOUT_CYCLES > 0);

`ifdef TL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_q;

  // A matching beat in the limit cycle takes priority over the timeout.
  assign to_hit = d_ready && !d_match && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // D-wait cycle counter: cleared while the A beat is pending, counts D_WAIT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (state_q == A_SEND) begin
      to_cnt_q <= '0;
    end else if (state_q == D_WAIT && !d_match) begin
      to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end

  // Timeout flag is latched alongside the rest of the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_timeout <= 1'b0;
    end else if (d_match) begin
      rsp_timeout <= 1'b0;
    end else if (to_hit) begin
      rsp_timeout <= 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_fire)          state_d = A_SEND;
      A_SEND:  if (a_ready)           state_d = D_WAIT;
      D_WAIT:  if (d_match || to_hit) state_d = RSP;
      RSP:     if (rsp_ready)         state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // State register plus handshake outputs registered from the next state,
  // so they are all low in reset and have no input-to-output path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      req_ready <= 1'b0;
      a_valid   <= 1'b0;
      d_ready   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == IDLE);
      a_valid   <= (state_d == A_SEND);
      d_ready   <= (state_d == D_WAIT);
      rsp_valid <= (state_d == RSP);
    end
  end

  // Request capture: A-channel fields are built once and held until a_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_opcode  <= '0;
      a_param   <= '0;
      a_address <= '0;
      a_size    <= '0;
      a_mask    <= '0;
      a_data    <= '0;
      a_source  <= '0;
      src_ctr_q <= '0;
      is_get_q  <= 1'b0;
    end else if (req_fire) begin
      if (!req_we) begin
        a_opcode <= OP_GET;
        a_mask   <= '1;
        a_data   <= '0;
      end else begin
        a_opcode <= (&req_wmask) ? OP_PUT_FULL : OP_PUT_PARTIAL;
        a_mask   <= req_wmask;
        a_data   <= req_wdata;
      end
      a_param   <= '0;
      a_address <= req_addr & ~ADDR_LOW;
      a_size    <= TL_SIZE_WIDTH'(OFF);
      a_source  <= src_ctr_q;
      src_ctr_q <= src_ctr_q + TL_SOURCE_WIDTH'(1);
      is_get_q  <= !req_we;
    end
  end

  // Response capture from the matching D beat (or the timeout).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else if (d_match) begin
      if (is_get_q) begin
        rsp_error <= d_error || (d_opcode != OP_ACK_DATA);
        rsp_rdata <= (!d_error && d_opcode == OP_ACK_DATA) ? d_data : '0;
      end else begin
        rsp_error <= d_error || (d_opcode != OP_ACK);
        rsp_rdata <= '0;
      end
    end else if (to_hit) begin
      rsp_error <= 1'b1;
      rsp_rdata <= '0;
    end
  end

  // One-cycle pulse for every discarded D beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stale_drop <= 1'b0;
    end else begin
      stale_drop <= d_stale;
    end
  end

endmodule

// File: tb/tb_tilelink_ul_master_adapter.sv
// Self-checking bench for tilelink_ul_master_adapter: directed transactions,
// expected A beats and responses queued at issue and checked by monitors.
`timescale 1ns/1ps

module tb_tilelink_ul_master_adapter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_error, rsp_timeout;
  logic        a_valid, a_ready = 1'b0;
  logic [2:0]  a_opcode, a_param, a_source;
  logic [63:0] a_address, a_data;
  logic [7:0]  a_size, a_mask;
  logic        d_valid = 1'b0, d_error = 1'b0, d_ready, stale_drop;
  logic [2:0]  d_opcode = '0, d_param = '0, d_sink = '0, d_source = '0;
  logic [7:0]  d_size = '0;
  logic [63:0] d_data = '0;

  tilelink_ul_master_adapter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .a_valid(a_valid), .a_opcode(a_opcode), .a_param(a_param),
    .a_address(a_address), .a_size(a_size), .a_mask(a_mask),
    .a_data(a_data), .a_source(a_source), .a_ready(a_ready),
    .d_valid(d_valid), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_sink(d_sink), .d_source(d_source),
    .d_data(d_data), .d_error(d_error), .d_ready(d_ready),
    .stale_drop(stale_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [2:0]  src;
  } a_exp_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic        to;
  } r_exp_t;

  a_exp_t aq[$];
  r_exp_t rq[$];
  int     n_cmp = 0;
  int     n_err = 0;
  logic [2:0] m_src = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A-channel monitor.
  always @(negedge clk) begin
    if (!reset && a_valid && a_ready) begin
      if (aq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL a_unexpected: got beat addr %h expected none", a_address);
      end else begin
        a_exp_t e;
        e = aq.pop_front();
        chk("a_opcode", 64'(a_opcode), 64'(e.op));
        chk("a_address", a_address, e.addr);
        chk("a_mask", 64'(a_mask), 64'(e.mask));
        chk("a_data", a_data, e.data);
        chk("a_source", 64'(a_source), 64'(e.src));
        chk("a_size", 64'(a_size), 64'd3);
        chk("a_param", 64'(a_param), 64'd0);
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (rq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rsp_unexpected: got rdata %h err %b expected none", rsp_rdata, rsp_error);
      end else begin
        r_exp_t r;
        r = rq.pop_front();
        chk("rsp_rdata", rsp_rdata, r.rdata);
        chk("rsp_error", 64'(rsp_error), 64'(r.err));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(r.to));
      end
    end
  end

  task automatic wait_req_ready();
    int i;
    i = 0;
    while (!req_ready && i < 40) begin
      @(posedge clk); #1;
      i++;
    end
    if (!req_ready) begin
      n_cmp++; n_err++;
      $display("FAIL req_ready_wait: got 0 expected 1 within 40 cycles");
    end
  endtask

  task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wmask, input logic [2:0] e_op, input logic [63:0] e_addr,
                       input logic [7:0] e_mask, input logic [63:0] e_data);
    a_exp_t e;
    wait_req_ready();
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    e.op = e_op; e.addr = e_addr; e.mask = e_mask; e.data = e_data; e.src = m_src;
    aq.push_back(e);
    @(posedge clk); #1;
    m_src = m_src + 3'd1;
    // scramble the request bus so held A fields must come from registers
    req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wdata; req_wmask = ~wmask; req_we = ~we;
  endtask

  task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] wmask, input logic [2:0] e_op, input logic [63:0] e_addr,
                     input logic [7:0] e_mask, input logic [63:0] e_data,
                     input logic [2:0] dop, input logic derr, input logic [63:0] ddat,
                     input logic [63:0] e_rdata, input logic e_err,
                     input int a_wait, input int n_stale, input int r_wait);
    r_exp_t r;
    logic [2:0] cur;
    cur = m_src;
    r.rdata = e_rdata; r.err = e_err; r.to = 1'b0;
    rq.push_back(r);
    issue(we, addr, wdata, wmask, e_op, e_addr, e_mask, e_data);
    chk("a_valid_lat", 64'(a_valid), 64'd1);
    chk("req_ready_busy", 64'(req_ready), 64'd0);
    for (int i = 0; i < a_wait; i++) begin
      @(posedge clk); #1;
      chk("a_hold_valid", 64'(a_valid), 64'd1);
      chk("a_hold_op", 64'(a_opcode), 64'(e_op));
      chk("a_hold_addr", a_address, e_addr);
      chk("a_hold_mask", 64'(a_mask), 64'(e_mask));
      chk("a_hold_data", a_data, e_data);
      chk("a_hold_src", 64'(a_source), 64'(cur));
    end
    a_ready = 1'b1;
    @(posedge clk); #1;
    a_ready = 1'b0;
    chk("d_ready_lat", 64'(d_ready), 64'd1);
    chk("a_valid_drop", 64'(a_valid), 64'd0);
    for (int i = 0; i < n_stale; i++) begin
      d_valid = 1'b1; d_source = ~cur; d_opcode = dop; d_error = 1'b0; d_data = 64'hBAD0BAD0BAD0BAD0;
      @(posedge clk); #1;
      chk("stale_pulse", 64'(stale_drop), 64'd1);
      chk("stale_stay", 64'(d_ready), 64'd1);
      chk("stale_no_rsp", 64'(rsp_valid), 64'd0);
    end
    d_valid = 1'b1; d_source = cur; d_opcode = dop; d_error = derr; d_data = ddat;
    @(posedge clk); #1;
    d_valid = 1'b0; d_error = 1'b0; d_data = '0;
    chk("rsp_valid_lat", 64'(rsp_valid), 64'd1);
    chk("stale_clear", 64'(stale_drop), 64'd0);
    chk("d_ready_off", 64'(d_ready), 64'd0);
    for (int i = 0; i < r_wait; i++) begin
      @(posedge clk); #1;
      chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_hold_busy", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_done", 64'(rsp_valid), 64'd0);
    chk("req_ready_back", 64'(req_ready), 64'd1);
  endtask

  function automatic logic [63:0] any_output();
    return 64'({req_ready, a_valid, d_ready, rsp_valid, rsp_error, rsp_timeout, stale_drop,
                |a_opcode, |a_param, |a_size, |a_source, |a_mask,
                |a_address, |a_data, |rsp_rdata});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("reset_outs", any_output(), 64'd0);
    #9 reset = 1'b0;
    #2;
    chk("req_ready_pre", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk("req_ready_rise", 64'(req_ready), 64'd1);

    // read: addr aligned down, mask all ones, data returned
    txn(1'b0, 64'h1007, 64'h1111, 8'h00, 3'd4, 64'h1000, 8'hFF, 64'h0,
        3'd1, 1'b0, 64'hDEADBEEF, 64'hDEADBEEF, 1'b0, 0, 0, 0);
    // full write
    txn(1'b1, 64'h2008, 64'h0123456789ABCDEF, 8'hFF, 3'd0, 64'h2008, 8'hFF, 64'h0123456789ABCDEF,
        3'd0, 1'b0, 64'hFFFF, 64'h0, 1'b0, 0, 0, 0);
    // partial write on source 2 with two stale beats (source 5) first
    txn(1'b1, 64'h300D, 64'hCAFEF00D12345678, 8'h0F, 3'd1, 64'h3008, 8'h0F, 64'hCAFEF00D12345678,
        3'd0, 1'b0, 64'h0, 64'h0, 1'b0, 0, 2, 0);
    // write answered with d_error
    txn(1'b1, 64'h4000, 64'h42, 8'hFF, 3'd0, 64'h4000, 8'hFF, 64'h42,
        3'd0, 1'b1, 64'h0, 64'h0, 1'b1, 0, 0, 0);
    // read answered with AccessAck (wrong opcode)
    txn(1'b0, 64'h5005, 64'h0, 8'h00, 3'd4, 64'h5000, 8'hFF, 64'h0,
        3'd0, 1'b0, 64'h1234, 64'h0, 1'b1, 0, 0, 0);
    // read answered with d_error
    txn(1'b0, 64'h6000, 64'h0, 8'h00, 3'd4, 64'h6000, 8'hFF, 64'h0,
        3'd1, 1'b1, 64'h5555, 64'h0, 1'b1, 0, 0, 0);
    // backpressure on A (5 cycles) and response (3 cycles)
    txn(1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 8'h00, 3'd4, 64'hFFFFFFFFFFFFFFF8, 8'hFF, 64'h0,
        3'd1, 1'b0, 64'hA5A5A5A55A5A5A5A, 64'hA5A5A5A55A5A5A5A, 1'b0, 5, 0, 3);
    // write with zero mask
    txn(1'b1, 64'h8001, 64'h77, 8'h00, 3'd1, 64'h8000, 8'h00, 64'h77,
        3'd0, 1'b0, 64'h0, 64'h0, 1'b0, 0, 0, 0);
    // ninth transaction wraps source to 0; AccessAckData to a put is an error
    txn(1'b1, 64'h9000, 64'h99, 8'hFF, 3'd0, 64'h9000, 8'hFF, 64'h99,
        3'd1, 1'b0, 64'h1, 64'h0, 1'b1, 0, 0, 0);

    // reset while in D_WAIT
    issue(1'b0, 64'hA000, 64'h0, 8'h00, 3'd4, 64'hA000, 8'hFF, 64'h0);
    a_ready = 1'b1;
    @(posedge clk); #1;
    a_ready = 1'b0;
    chk("mid_d_ready", 64'(d_ready), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_outs", any_output(), 64'd0);
    m_src = '0;
    d_valid = 1'b1; d_source = 3'd1; d_opcode = 3'd1; d_data = 64'h1;
    #3 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_ready", 64'(req_ready), 64'd1);
    chk("post_reset_d_ready", 64'(d_ready), 64'd0);
    @(posedge clk); #1;
    d_valid = 1'b0;
    chk("late_rsp_ignored", 64'(rsp_valid), 64'd0);
    chk("late_no_stale", 64'(stale_drop), 64'd0);
    // source counter restarts at 0
    txn(1'b0, 64'hB010, 64'h0, 8'h00, 3'd4, 64'hB010, 8'hFF, 64'h0,
        3'd1, 1'b0, 64'h0BADF00D, 64'h0BADF00D, 1'b0, 0, 1, 0);

`ifdef TL_MASTER_TIMEOUT_EN
    begin
      r_exp_t r;
      r.rdata = '0; r.err = 1'b1; r.to = 1'b1;
      rq.push_back(r);
      issue(1'b0, 64'hC000, 64'h0, 8'h00, 3'd4, 64'hC000, 8'hFF, 64'h0);
      a_ready = 1'b1;
      @(posedge clk); #1;
      a_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
        @(posedge clk); #1;
        chk("to_waiting", 64'(rsp_valid), 64'd0);
      end
      @(posedge clk); #1;
      chk("to_fire", 64'(rsp_valid), 64'd1);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      // next request sees a stale beat before its own response
      txn(1'b0, 64'hD000, 64'h0, 8'h00, 3'd4, 64'hD000, 8'hFF, 64'h0,
          3'd1, 1'b0, 64'h3, 64'h3, 1'b0, 0, 1, 0);
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("aq_empty", 64'(aq.size()), 64'd0);
    chk("rq_empty", 64'(rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
